// File: rtl/or1200_wb_mem_arbiter.sv
// Two-master (iwb/dwb) to one-slave Wishbone arbiter in front of a shared OR1200 memory.
// Round-robin or dwb-priority arbitration, per-tenure beat cap and slave response timeout.
module or1200_wb_mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int PRIO_MODE = 0,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  // instruction master
  input  logic              iwb_cyc_i,
  input  logic              iwb_stb_i,
  input  logic              iwb_we_i,
  input  logic [AW-1:0]     iwb_adr_i,
  input  logic [DW-1:0]     iwb_dat_i,
  input  logic [DW/8-1:0]   iwb_sel_i,
  input  logic [2:0]        iwb_cti_i,
  input  logic [1:0]        iwb_bte_i,
  output logic              iwb_ack_o,
  output logic              iwb_err_o,
  output logic              iwb_rty_o,
  output logic [DW-1:0]     iwb_dat_o,
  // data master
  input  logic              dwb_cyc_i,
  input  logic              dwb_stb_i,
  input  logic              dwb_we_i,
  input  logic [AW-1:0]     dwb_adr_i,
  input  logic [DW-1:0]     dwb_dat_i,
  input  logic [DW/8-1:0]   dwb_sel_i,
  input  logic [2:0]        dwb_cti_i,
  input  logic [1:0]        dwb_bte_i,
  output logic              dwb_ack_o,
  output logic              dwb_err_o,
  output logic              dwb_rty_o,
  output logic [DW-1:0]     dwb_dat_o,
  // shared slave
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic [2:0]        s_cti_o,
  output logic [1:0]        s_bte_o,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_rty_i,
  input  logic [DW-1:0]     s_dat_i,
  output logic [1:0]        gnt_o
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
  localparam logic [BW-1:0] BEAT_SAT  = BW'(MAX_BURST);
  localparam logic [TW-1:0] TO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            last_d;
  logic            last_d_nxt;
  logic [BW-1:0]   beat_cnt;
  logic [TW-1:0]   to_cnt;

  logic            iwb_req;
  logic            dwb_req;
  logic            other_req;
  logic            busy;
  logic            resp;
  logic            to_hit;
  logic            single_cti;
  logic            cut;
  logic            tenure_end;

  assign iwb_req = iwb_cyc_i & iwb_stb_i;
  assign dwb_req = dwb_cyc_i & dwb_stb_i;
  assign busy    = (state != IDLE);
  assign resp    = s_ack_i | s_err_i | s_rty_i;

  // Slave port is a plain mux of the granted master; idle drives all zeros.
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_cti_o   = '0;
    s_bte_o   = '0;
    other_req = 1'b0;
    case (state)
      BUSY_I: begin
        s_cyc_o   = iwb_cyc_i;
        s_stb_o   = iwb_stb_i;
        s_we_o    = iwb_we_i;
        s_adr_o   = iwb_adr_i;
        s_dat_o   = iwb_dat_i;
        s_sel_o   = iwb_sel_i;
        s_cti_o   = iwb_cti_i;
        s_bte_o   = iwb_bte_i;
        other_req = dwb_req;
      end
      BUSY_D: begin
        s_cyc_o   = dwb_cyc_i;
        s_stb_o   = dwb_stb_i;
        s_we_o    = dwb_we_i;
        s_adr_o   = dwb_adr_i;
        s_dat_o   = dwb_dat_i;
        s_sel_o   = dwb_sel_i;
        s_cti_o   = dwb_cti_i;
        s_bte_o   = dwb_bte_i;
        other_req = iwb_req;
      end
      default: ;
    endcase
  end

  // A real slave response always beats the timeout in the same cycle.
  assign to_hit     = (TIMEOUT != 0) && s_stb_o && !resp && (to_cnt == TO_LAST);
  assign single_cti = (s_cti_o == 3'b000) || (s_cti_o == 3'b111);
  assign cut        = busy && resp && other_req && (single_cti || (beat_cnt == BEAT_LAST));
  assign tenure_end = busy && (!s_cyc_o || cut || to_hit);

  assign iwb_dat_o = s_dat_i;
  assign dwb_dat_o = s_dat_i;

  // Responses are masked while rst is high so an aborted tenure never sees an ack.
  always_comb begin
    iwb_ack_o = 1'b0;
    iwb_err_o = 1'b0;
    iwb_rty_o = 1'b0;
    dwb_ack_o = 1'b0;
    dwb_err_o = 1'b0;
    dwb_rty_o = 1'b0;
    if (!rst) begin
      if (state == BUSY_I) begin
        iwb_ack_o = s_ack_i;
        iwb_err_o = s_err_i | to_hit;
        iwb_rty_o = s_rty_i;
      end
      if (state == BUSY_D) begin
        dwb_ack_o = s_ack_i;
        dwb_err_o = s_err_i | to_hit;
        dwb_rty_o = s_rty_i;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    case (state)
      IDLE: begin
        if (iwb_req && dwb_req) begin
          if ((PRIO_MODE != 0) || !last_d) state_nxt = BUSY_D;
          else                             state_nxt = BUSY_I;
        end else if (dwb_req) begin
          state_nxt = BUSY_D;
        end else if (iwb_req) begin
          state_nxt = BUSY_I;
        end
      end
      BUSY_I: begin
        if (tenure_end) begin
          last_d_nxt = 1'b0;
          state_nxt  = dwb_req ? BUSY_D : IDLE;
        end
      end
      BUSY_D: begin
        if (tenure_end) begin
          last_d_nxt = 1'b1;
          state_nxt  = iwb_req ? BUSY_I : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b0;
      gnt_o  <= '0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
      case (state_nxt)
        BUSY_I:  gnt_o <= 2'b01;
        BUSY_D:  gnt_o <= 2'b10;
        default: gnt_o <= 2'b00;
      endcase
    end
  end

  // beat_cnt only counts beats taken while the other master is waiting.
  always_ff @(posedge clk) begin
    if (rst || !busy || tenure_end) begin
      beat_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      if (resp && other_req && (beat_cnt != BEAT_SAT))
        beat_cnt <= beat_cnt + 1'b1;
      if (resp)
        to_cnt <= '0;
      else if (s_stb_o && (TIMEOUT != 0))
        to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_or1200_wb_mem_arbiter.sv
// Directed bench for or1200_wb_mem_arbiter: a round-robin instance and a dwb-priority instance
// share master stimulus; a one-cycle-latency slave model answers whichever instance sel_p picks.
module tb_or1200_wb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic        iwb_cyc, iwb_stb, iwb_we;
  logic [31:0] iwb_adr, iwb_wdat;
  logic [3:0]  iwb_sel;
  logic [2:0]  iwb_cti;
  logic [1:0]  iwb_bte;
  logic        dwb_cyc, dwb_stb, dwb_we;
  logic [31:0] dwb_adr, dwb_wdat;
  logic [3:0]  dwb_sel;
  logic [2:0]  dwb_cti;
  logic [1:0]  dwb_bte;

  logic        s_ack, s_err, s_rty;
  logic [31:0] s_rdat;

  // round-robin instance outputs
  logic        iwb_ack, iwb_err, iwb_rty, dwb_ack, dwb_err, dwb_rty;
  logic [31:0] iwb_rdat, dwb_rdat;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdat;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic [1:0]  gnt;

  // priority instance outputs
  logic        iwb_ack_p, iwb_err_p, iwb_rty_p, dwb_ack_p, dwb_err_p, dwb_rty_p;
  logic [31:0] iwb_rdat_p, dwb_rdat_p;
  logic        s_cyc_p, s_stb_p, s_we_p;
  logic [31:0] s_adr_p, s_wdat_p;
  logic [3:0]  s_sel_p;
  logic [2:0]  s_cti_p;
  logic [1:0]  s_bte_p;
  logic [1:0]  gnt_p;

  logic        slv_en;
  logic        sel_p;
  logic        sv_cyc, sv_stb;
  logic [31:0] sv_adr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  or1200_wb_mem_arbiter #(.AW(32), .DW(32), .PRIO_MODE(0), .MAX_BURST(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .iwb_cyc_i(iwb_cyc), .iwb_stb_i(iwb_stb), .iwb_we_i(iwb_we), .iwb_adr_i(iwb_adr),
    .iwb_dat_i(iwb_wdat), .iwb_sel_i(iwb_sel), .iwb_cti_i(iwb_cti), .iwb_bte_i(iwb_bte),
    .iwb_ack_o(iwb_ack), .iwb_err_o(iwb_err), .iwb_rty_o(iwb_rty), .iwb_dat_o(iwb_rdat),
    .dwb_cyc_i(dwb_cyc), .dwb_stb_i(dwb_stb), .dwb_we_i(dwb_we), .dwb_adr_i(dwb_adr),
    .dwb_dat_i(dwb_wdat), .dwb_sel_i(dwb_sel), .dwb_cti_i(dwb_cti), .dwb_bte_i(dwb_bte),
    .dwb_ack_o(dwb_ack), .dwb_err_o(dwb_err), .dwb_rty_o(dwb_rty), .dwb_dat_o(dwb_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_wdat),
    .s_sel_o(s_sel), .s_cti_o(s_cti), .s_bte_o(s_bte),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .s_dat_i(s_rdat),
    .gnt_o(gnt)
  );

  or1200_wb_mem_arbiter #(.AW(32), .DW(32), .PRIO_MODE(1), .MAX_BURST(4), .TIMEOUT(64)) dut_p (
    .clk(clk), .rst(rst),
    .iwb_cyc_i(iwb_cyc), .iwb_stb_i(iwb_stb), .iwb_we_i(iwb_we), .iwb_adr_i(iwb_adr),
    .iwb_dat_i(iwb_wdat), .iwb_sel_i(iwb_sel), .iwb_cti_i(iwb_cti), .iwb_bte_i(iwb_bte),
    .iwb_ack_o(iwb_ack_p), .iwb_err_o(iwb_err_p), .iwb_rty_o(iwb_rty_p), .iwb_dat_o(iwb_rdat_p),
    .dwb_cyc_i(dwb_cyc), .dwb_stb_i(dwb_stb), .dwb_we_i(dwb_we), .dwb_adr_i(dwb_adr),
    .dwb_dat_i(dwb_wdat), .dwb_sel_i(dwb_sel), .dwb_cti_i(dwb_cti), .dwb_bte_i(dwb_bte),
    .dwb_ack_o(dwb_ack_p), .dwb_err_o(dwb_err_p), .dwb_rty_o(dwb_rty_p), .dwb_dat_o(dwb_rdat_p),
    .s_cyc_o(s_cyc_p), .s_stb_o(s_stb_p), .s_we_o(s_we_p), .s_adr_o(s_adr_p), .s_dat_o(s_wdat_p),
    .s_sel_o(s_sel_p), .s_cti_o(s_cti_p), .s_bte_o(s_bte_p),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .s_dat_i(s_rdat),
    .gnt_o(gnt_p)
  );

  assign sv_cyc = sel_p ? s_cyc_p : s_cyc;
  assign sv_stb = sel_p ? s_stb_p : s_stb;
  assign sv_adr = sel_p ? s_adr_p : s_adr;

  // Slave: acks one cycle after it sees stb, never two cycles in a row; data tags the address.
  always @(posedge clk) begin
    if (!slv_en) s_ack <= 1'b0;
    else         s_ack <= sv_cyc & sv_stb & ~s_ack;
    s_rdat <= {16'hD00D, sv_adr[15:0]};
  end

  task idle_masters;
    iwb_cyc = 1'b0; iwb_stb = 1'b0; iwb_we = 1'b0; iwb_adr = '0; iwb_wdat = '0;
    iwb_sel = 4'hF; iwb_cti = 3'b000; iwb_bte = 2'b00;
    dwb_cyc = 1'b0; dwb_stb = 1'b0; dwb_we = 1'b0; dwb_adr = '0; dwb_wdat = '0;
    dwb_sel = 4'hF; dwb_cti = 3'b000; dwb_bte = 2'b00;
  endtask

  task test_reset;
    rst = 1'b1; slv_en = 1'b1; sel_p = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    idle_masters();
    iwb_cyc = 1'b1; iwb_stb = 1'b1; iwb_adr = 32'h0000_0010;
    dwb_cyc = 1'b1; dwb_stb = 1'b1; dwb_adr = 32'h0000_0020;
    repeat (2) begin
      @(negedge clk);
      total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
      total++; if ({s_cyc, s_stb} !== 2'b00) begin bad++; $display("FAIL reset_s_cyc: got %b want 00", {s_cyc, s_stb}); end
      total++; if ({iwb_ack, iwb_err, iwb_rty, dwb_ack, dwb_err, dwb_rty} !== 6'b0)
        begin bad++; $display("FAIL reset_resp: got %b want 000000", {iwb_ack, iwb_err, iwb_rty, dwb_ack, dwb_err, dwb_rty}); end
    end
    rst = 1'b0;
    @(negedge clk);
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL reset_first_gnt: got %b want 10", gnt); end
    total++; if (s_adr !== 32'h0000_0020) begin bad++; $display("FAIL reset_first_adr: got %h want 00000020", s_adr); end
    idle_masters();
    repeat (2) @(negedge clk);
  endtask

  task test_single_read;
    iwb_cyc = 1'b1; iwb_stb = 1'b1; iwb_adr = 32'h0000_0100;
    #1;
    total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL single_not_comb: got %b want 0", s_cyc); end
    @(negedge clk);
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL single_gnt: got %b want 01", gnt); end
    total++; if (s_adr !== 32'h0000_0100) begin bad++; $display("FAIL single_adr: got %h want 00000100", s_adr); end
    total++; if ({s_stb, iwb_ack} !== 2'b10) begin bad++; $display("FAIL single_stb_noack: got %b want 10", {s_stb, iwb_ack}); end
    @(negedge clk);
    total++; if (iwb_ack !== 1'b1) begin bad++; $display("FAIL single_ack: got %b want 1", iwb_ack); end
    total++; if (iwb_rdat !== 32'hD00D_0100) begin bad++; $display("FAIL single_data: got %h want d00d0100", iwb_rdat); end
    total++; if (dwb_ack !== 1'b0) begin bad++; $display("FAIL single_dwb_quiet: got %b want 0", dwb_ack); end
    idle_masters();
    @(negedge clk);
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL single_release: got %b want 00", gnt); end
    @(negedge clk);
  endtask

  task test_round_robin;
    logic [1:0] exp_g;
    logic       exp_ack;
    iwb_cyc = 1'b1; iwb_stb = 1'b1; iwb_adr = 32'h0000_0200;
    dwb_cyc = 1'b1; dwb_stb = 1'b1; dwb_adr = 32'h0000_0300;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_g   = (((k - 1) / 2) % 2 == 0) ? 2'b10 : 2'b01;
      exp_ack = (k % 2 == 0);
      total++; if (gnt !== exp_g) begin bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, exp_g); end
      total++; if ({dwb_ack, iwb_ack} !== ({2{exp_ack}} & exp_g))
        begin bad++; $display("FAIL rr_ack[%0d]: got %b want %b", k, {dwb_ack, iwb_ack}, {2{exp_ack}} & exp_g); end
    end
    idle_masters();
    repeat (2) @(negedge clk);
  endtask

  task test_burst_cap;
    int  ibeats;
    int  dacks;
    bit  d_seen;
    bit  prev_iack;
    bit  prev_dack;
    iwb_cyc = 1'b1; iwb_stb = 1'b1; iwb_cti = 3'b010; iwb_adr = 32'h0000_0400;
    @(negedge clk);
    dwb_cyc = 1'b1; dwb_stb = 1'b1; dwb_cti = 3'b000; dwb_adr = 32'h0000_0500;
    ibeats = 0; dacks = 0; d_seen = 1'b0; prev_iack = 1'b0; prev_dack = 1'b0;
    for (int n = 0; n < 80 && ibeats < 16; n++) begin
      @(negedge clk);
      if (prev_iack && ibeats == 4) begin
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL cap_handoff: got %b want 10", gnt); end
      end
      if (prev_dack) begin
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL cap_resume_gnt: got %b want 01", gnt); end
        total++; if (s_adr !== 32'h0000_0410) begin bad++; $display("FAIL cap_resume_adr: got %h want 00000410", s_adr); end
      end
      if (!d_seen && gnt == 2'b10) begin
        d_seen = 1'b1;
        total++; if (ibeats != 4) begin bad++; $display("FAIL cap_count: got %0d want 4", ibeats); end
      end
      prev_iack = iwb_ack;
      prev_dack = dwb_ack;
      if (iwb_ack) begin
        ibeats++;
        iwb_adr = iwb_adr + 32'd4;
        if (ibeats == 15) iwb_cti = 3'b111;
        if (ibeats == 16) begin iwb_cyc = 1'b0; iwb_stb = 1'b0; end
      end
      if (dwb_ack) begin
        dacks++;
        dwb_cyc = 1'b0; dwb_stb = 1'b0;
      end
    end
    total++; if (ibeats != 16) begin bad++; $display("FAIL cap_burst_done: got %0d beats want 16", ibeats); end
    total++; if (dacks != 1) begin bad++; $display("FAIL cap_dwb_acks: got %0d want 1", dacks); end
    idle_masters();
    repeat (2) @(negedge clk);
  endtask

  task test_timeout;
    slv_en = 1'b0;
    dwb_cyc = 1'b1; dwb_stb = 1'b1; dwb_we = 1'b1; dwb_adr = 32'h0000_0600; dwb_wdat = 32'hCAFE_F00D;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      total++; if (dwb_err !== (k == 16)) begin bad++; $display("FAIL to_err[%0d]: got %b want %b", k, dwb_err, (k == 16)); end
      total++; if (s_cyc !== 1'b1) begin bad++; $display("FAIL to_cyc_held[%0d]: got %b want 1", k, s_cyc); end
    end
    total++; if (iwb_err !== 1'b0) begin bad++; $display("FAIL to_iwb_quiet: got %b want 0", iwb_err); end
    @(negedge clk);
    total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL to_cyc_drop: got %b want 0", s_cyc); end
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL to_gnt: got %b want 00", gnt); end
    total++; if (dwb_err !== 1'b0) begin bad++; $display("FAIL to_err_pulse: got %b want 0", dwb_err); end
    idle_masters();
    slv_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task test_prio;
    sel_p = 1'b1;
    idle_masters();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dwb_cyc = 1'b1; dwb_stb = 1'b1; dwb_adr = 32'h0000_0700;
    @(negedge clk);
    total++; if (gnt_p !== 2'b10) begin bad++; $display("FAIL prio_single_gnt: got %b want 10", gnt_p); end
    @(negedge clk);
    total++; if (dwb_ack_p !== 1'b1) begin bad++; $display("FAIL prio_single_ack: got %b want 1", dwb_ack_p); end
    idle_masters();
    @(negedge clk);
    total++; if (gnt_p !== 2'b00) begin bad++; $display("FAIL prio_idle: got %b want 00", gnt_p); end
    // dwb was granted last, so only priority (not round-robin) hands this tie to dwb
    iwb_cyc = 1'b1; iwb_stb = 1'b1; iwb_adr = 32'h0000_0800;
    dwb_cyc = 1'b1; dwb_stb = 1'b1; dwb_adr = 32'h0000_0900; dwb_cti = 3'b010;
    @(negedge clk);
    total++; if (gnt_p !== 2'b10) begin bad++; $display("FAIL prio_tie: got %b want 10", gnt_p); end
    @(negedge clk);
    total++; if ({dwb_ack_p, iwb_ack_p} !== 2'b10) begin bad++; $display("FAIL prio_burst_ack: got %b want 10", {dwb_ack_p, iwb_ack_p}); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (s_cyc_p !== 1'b0) begin bad++; $display("FAIL prio_rst_cyc: got %b want 0", s_cyc_p); end
    total++; if (gnt_p !== 2'b00) begin bad++; $display("FAIL prio_rst_gnt: got %b want 00", gnt_p); end
    total++; if ({dwb_ack_p, iwb_ack_p} !== 2'b00) begin bad++; $display("FAIL prio_rst_ack: got %b want 00", {dwb_ack_p, iwb_ack_p}); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (gnt_p !== 2'b10) begin bad++; $display("FAIL prio_after_rst: got %b want 10", gnt_p); end
    @(negedge clk);
    total++; if (dwb_ack_p !== 1'b1) begin bad++; $display("FAIL prio_after_rst_ack: got %b want 1", dwb_ack_p); end
    dwb_cyc = 1'b0; dwb_stb = 1'b0; dwb_cti = 3'b000;
    @(negedge clk);
    total++; if (gnt_p !== 2'b01) begin bad++; $display("FAIL prio_to_iwb: got %b want 01", gnt_p); end
    dwb_cyc = 1'b1; dwb_stb = 1'b1;
    @(negedge clk);
    total++; if (iwb_ack_p !== 1'b1) begin bad++; $display("FAIL prio_iwb_ack: got %b want 1", iwb_ack_p); end
    @(negedge clk);
    total++; if (gnt_p !== 2'b10) begin bad++; $display("FAIL prio_handoff: got %b want 10", gnt_p); end
    idle_masters();
    repeat (2) @(negedge clk);
    sel_p = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_cap();
    test_timeout();
    test_prio();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
